// File: rtl/pc_fetch_ctrl.sv
// Fetch-side PC generator for the IF/ID pipeline register: steps the PC, loads
// branch targets, and squashes wrong-path fetches with a timed flush pulse.
module pc_fetch_ctrl #(
  parameter int PC_W         = 4,
  parameter int PC_STEP      = 1,
  parameter int RESET_PC     = 0,
  parameter int FLUSH_CYCLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            br_taken,
  input  logic [PC_W-1:0] br_target,
  output logic [PC_W-1:0] pc_out,
  output logic            pc_valid,
  output logic            flush_ir,
  output logic            busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [PC_W-1:0] RESET_PC_V = PC_W'(RESET_PC);
  localparam logic [PC_W-1:0] STEP_V     = PC_W'(PC_STEP);
  localparam logic [2:0]      CNT_INIT   = 3'(FLUSH_CYCLES - 1);

  state_t          state_q;
  logic [2:0]      cnt_q;
  logic [PC_W-1:0] pc_q;
  logic            valid_q;
  logic            flush_q;
  logic            busy_q;

  logic [PC_W-1:0] pc_inc_d;
  logic [2:0]      cnt_dec_d;

  // Natural wrap of the adder gives the required modulo-2**PC_W arithmetic.
  assign pc_inc_d  = pc_q + STEP_V;
  assign cnt_dec_d = cnt_q - 3'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      pc_q    <= RESET_PC_V;
      valid_q <= 1'b0;
      flush_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE, RUN: begin
          if (br_taken) begin
            pc_q    <= br_target;
            valid_q <= 1'b0;
            flush_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= CNT_INIT;
            state_q <= FLUSH;
          end else if (state_q == IDLE) begin
            state_q <= RUN;
            valid_q <= 1'b1;
          end else if (!stall) begin
            pc_q <= pc_inc_d;
          end
        end
        FLUSH: begin
          // Stall is deliberately ignored here so the flush length stays fixed.
          if (br_taken) begin
            pc_q  <= br_target;
            cnt_q <= CNT_INIT;
          end else if (cnt_q == 3'd0) begin
            state_q <= RUN;
            flush_q <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_dec_d;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
          flush_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign pc_out   = pc_q;
  assign pc_valid = valid_q;
  assign flush_ir = flush_q;
  assign busy     = busy_q;

endmodule
